// File: rtl/mono_pkg.sv
// Shared definitions for the Monopix hit ToT processor: FSM states, hit word
// field layout, output word layout and counter helpers.
package mono_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TS_W    = 8;
  localparam int unsigned ROW_W   = 8;
  localparam int unsigned COL_W   = 6;

  // Input word MSB positions: {id, le, te, row, col}
  localparam int unsigned ID_MSB  = 31;
  localparam int unsigned LE_MSB  = 29;
  localparam int unsigned TE_MSB  = 21;
  localparam int unsigned ROW_MSB = 13;
  localparam int unsigned COL_MSB = 5;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_CAPT = 4'b0100,
    ST_PROC = 4'b1000
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TS_W-1:0]  le;
    logic [TS_W-1:0]  te;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } hit_word_t;

  // Readout word handed to the arbiter
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TS_W-1:0]  le;
    logic [TS_W-1:0]  tot;
  } out_word_t;

  function automatic logic [TS_W-1:0] calc_tot(input logic [TS_W-1:0] le,
                                               input logic [TS_W-1:0] te);
    return TS_W'(te - le);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : CNT_W'(v + CNT_W'(1));
  endfunction

endpackage

// File: rtl/mono_tot_out_fifo.sv
// First-word-fall-through FIFO with registered head, full and empty flags.
module mono_tot_out_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count, count_n;
  logic             do_wr_c, do_rd_c;

  assign do_wr_c = wr_en && !full;
  assign do_rd_c = rd_en && !empty;

  always_comb begin
    rd_ptr_n = rd_ptr;
    count_n  = count;
    if (do_rd_c) rd_ptr_n = AW'(rd_ptr + AW'(1));
    count_n = CW'(count + CW'(do_wr_c) - CW'(do_rd_c));
  end

  // Head register tracks whichever entry will sit at rd_ptr after this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_wr_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= AW'(wr_ptr + AW'(1));
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (count_n == CW'(DEPTH));
      empty  <= (count_n == '0);
      if (count_n == '0)
        rd_data <= '0;
      else if (do_wr_c && (wr_ptr == rd_ptr_n))
        rd_data <= wr_data;
      else
        rd_data <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/mono_hit_tot_proc.sv
// Monopix hit processor: pops hit words, computes 8-bit wrapping ToT, filters
// by threshold and column range, and queues readout words in an output FIFO.
module mono_hit_tot_proc
  import mono_pkg::*;
#(
  parameter int unsigned N_COLS    = 36,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST_N,
  input  logic              CONF_EN,
  input  logic [7:0]        CONF_TOT_MIN,
  input  logic              IN_EMPTY,
  output logic              IN_READ,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              OUT_READ,
  output logic              OUT_EMPTY,
  output logic [WORD_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  HIT_CNT,
  output logic [CNT_W-1:0]  DROP_CNT,
  output logic [CNT_W-1:0]  ERR_CNT
);

  state_t           state, state_n;
  hit_word_t        hit_q;
  logic             in_read_q;
  logic             out_full;
  logic [TS_W-1:0]  tot_c;
  logic             col_err_c, tot_low_c, out_wr_c;
  out_word_t        out_word_c;
  logic [CNT_W-1:0] hit_cnt_q, drop_cnt_q, err_cnt_q;

  assign IN_READ  = in_read_q;
  assign HIT_CNT  = hit_cnt_q;
  assign DROP_CNT = drop_cnt_q;
  assign ERR_CNT  = err_cnt_q;

  // Classification of the captured word; column error outranks threshold
  always_comb begin
    tot_c          = calc_tot(hit_q.le, hit_q.te);
    col_err_c      = (32'(hit_q.col) >= 32'(N_COLS));
    tot_low_c      = (tot_c < CONF_TOT_MIN);
    out_wr_c       = (state == ST_PROC) && !col_err_c && !tot_low_c;
    out_word_c     = '0;
    out_word_c.id  = hit_q.id;
    out_word_c.col = hit_q.col;
    out_word_c.row = hit_q.row;
    out_word_c.le  = hit_q.le;
    out_word_c.tot = tot_c;
  end

  // Only admit a word when the FIFO has room, so the PROC write never overflows
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (CONF_EN && !IN_EMPTY && !out_full) state_n = ST_REQ;
      ST_REQ:  state_n = ST_CAPT;
      ST_CAPT: state_n = ST_PROC;
      ST_PROC: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= ST_IDLE;
      in_read_q <= 1'b0;
      hit_q     <= '0;
    end else begin
      state     <= state_n;
      in_read_q <= (state_n == ST_REQ);
      if (state == ST_CAPT) begin
        hit_q.id  <= IN_DATA[ID_MSB  -: ID_W];
        hit_q.le  <= IN_DATA[LE_MSB  -: TS_W];
        hit_q.te  <= IN_DATA[TE_MSB  -: TS_W];
        hit_q.row <= IN_DATA[ROW_MSB -: ROW_W];
        hit_q.col <= IN_DATA[COL_MSB -: COL_W];
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (state == ST_PROC) begin
      if (col_err_c)      err_cnt_q  <= sat_inc(err_cnt_q);
      else if (tot_low_c) drop_cnt_q <= sat_inc(drop_cnt_q);
      else                hit_cnt_q  <= sat_inc(hit_cnt_q);
    end
  end

  mono_tot_out_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (BUS_CLK),
    .rst_n   (BUS_RST_N),
    .wr_en   (out_wr_c),
    .wr_data (out_word_c),
    .rd_en   (OUT_READ),
    .rd_data (OUT_DATA),
    .full    (out_full),
    .empty   (OUT_EMPTY)
  );

endmodule

// File: tb/tb_mono_hit_tot_proc.sv
// Scoreboard bench for mono_hit_tot_proc with a behavioural upstream FIFO.
module tb_mono_hit_tot_proc;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N;
  logic        CONF_EN;
  logic [7:0]  CONF_TOT_MIN;
  logic        IN_EMPTY;
  logic        IN_READ;
  logic [31:0] IN_DATA;
  logic        OUT_READ;
  logic        OUT_EMPTY;
  logic [31:0] OUT_DATA;
  logic [15:0] HIT_CNT, DROP_CNT, ERR_CNT;

  mono_hit_tot_proc #(.N_COLS(36), .OUT_DEPTH(4)) dut (
    .BUS_CLK      (BUS_CLK),
    .BUS_RST_N    (BUS_RST_N),
    .CONF_EN      (CONF_EN),
    .CONF_TOT_MIN (CONF_TOT_MIN),
    .IN_EMPTY     (IN_EMPTY),
    .IN_READ      (IN_READ),
    .IN_DATA      (IN_DATA),
    .OUT_READ     (OUT_READ),
    .OUT_EMPTY    (OUT_EMPTY),
    .OUT_DATA     (OUT_DATA),
    .HIT_CNT      (HIT_CNT),
    .DROP_CNT     (DROP_CNT),
    .ERR_CNT      (ERR_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [31:0] up_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] exp_hit, exp_drop, exp_err;
  int          n_checks, n_errors;
  int          rd_mode;
  int          rd_pulses;
  int          p0;
  bit          underflow;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind: 0 accepted, 1 dropped by threshold, 2 bad column
  task automatic push_hit(input logic [1:0] id, input logic [7:0] le, input logic [7:0] te,
                          input logic [7:0] row, input logic [5:0] col, input int kind,
                          input logic [31:0] exp_word);
    up_q.push_back({id, le, te, row, col});
    case (kind)
      0: begin
        exp_q.push_back(exp_word);
        if (exp_hit != 16'hFFFF) exp_hit++;
      end
      1: exp_drop++;
      default: exp_err++;
    endcase
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, ".hit"},  32'(HIT_CNT),  32'(exp_hit));
    chk({tag, ".drop"}, 32'(DROP_CNT), 32'(exp_drop));
    chk({tag, ".err"},  32'(ERR_CNT),  32'(exp_err));
  endtask

  task automatic wait_in_read(input string tag, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge BUS_CLK);
      if (IN_READ) begin
        seen = 1;
        break;
      end
    end
    chk({tag, ".in_read_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge BUS_CLK);
      if (exp_q.size() == 0 && up_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    repeat (8) @(negedge BUS_CLK);
    chk({tag, ".drain_done"}, 32'(done), 32'd1);
  endtask

  // Upstream FIFO: data appears the cycle after IN_READ
  task automatic upstream_loop();
    bit pend;
    forever begin
      @(negedge BUS_CLK);
      pend = IN_READ;
      @(posedge BUS_CLK);
      if (pend) begin
        rd_pulses++;
        if (up_q.size() == 0) underflow = 1;
        else IN_DATA <= up_q.pop_front();
      end
      IN_EMPTY <= (up_q.size() == 0);
    end
  endtask

  // Consumer and scoreboard: every popped head must match the oldest expectation
  task automatic monitor_loop();
    bit rd;
    logic [31:0] e;
    forever begin
      @(negedge BUS_CLK);
      rd = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(1, 0) == 1);
      if (!BUS_RST_N || !rd || OUT_EMPTY) begin
        OUT_READ = 1'b0;
      end else begin
        OUT_READ = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h expected none", OUT_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", OUT_DATA, e);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; rd_mode = 0; rd_pulses = 0; underflow = 0;
    exp_hit = 0; exp_drop = 0; exp_err = 0;
    BUS_RST_N = 1'b0; CONF_EN = 1'b0; CONF_TOT_MIN = 8'd0;
    IN_EMPTY = 1'b1; IN_DATA = 32'd0; OUT_READ = 1'b0;
    fork
      upstream_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge BUS_CLK);
    chk("rst.out_empty", 32'(OUT_EMPTY), 32'd1);
    chk("rst.out_data",  OUT_DATA, 32'd0);
    chk("rst.in_read",   32'(IN_READ), 32'd0);
    check_cnts("rst");
    BUS_RST_N = 1'b1;
    @(negedge BUS_CLK);
    CONF_EN = 1'b1;

    // Single hit, latency walk
    push_hit(2'd2, 8'd10, 8'd25, 8'd100, 6'd5, 0, {2'd2, 6'd5, 8'd100, 8'd10, 8'd15});
    wait_in_read("single", 20);
    @(negedge BUS_CLK);
    chk("single.in_read_one_cycle", 32'(IN_READ), 32'd0);
    chk("single.c2_empty", 32'(OUT_EMPTY), 32'd1);
    @(negedge BUS_CLK);
    chk("single.c3_empty", 32'(OUT_EMPTY), 32'd1);
    chk("single.c3_hit", 32'(HIT_CNT), 32'd0);
    @(negedge BUS_CLK);
    chk("single.c4_empty", 32'(OUT_EMPTY), 32'd0);
    chk("single.c4_data", OUT_DATA, {2'd2, 6'd5, 8'd100, 8'd10, 8'd15});
    chk("single.c4_hit", 32'(HIT_CNT), 32'd1);
    rd_mode = 1;
    wait_drain("single", 100);

    // ToT wrap-around and zero ToT
    push_hit(2'd1, 8'd250, 8'd3, 8'd7,   6'd0,  0, {2'd1, 6'd0,  8'd7,   8'd250, 8'd9});
    push_hit(2'd3, 8'd7,   8'd7, 8'd255, 6'd35, 0, {2'd3, 6'd35, 8'd255, 8'd7,   8'd0});
    wait_drain("wrap", 200);
    check_cnts("wrap");

    // Threshold and column filters, including priority of column error
    CONF_TOT_MIN = 8'd20;
    push_hit(2'd0, 8'd100, 8'd119, 8'd1, 6'd1,  1, 32'd0);
    push_hit(2'd0, 8'd100, 8'd120, 8'd2, 6'd2,  0, {2'd0, 6'd2, 8'd2, 8'd100, 8'd20});
    push_hit(2'd2, 8'd0,   8'd50,  8'd3, 6'd36, 2, 32'd0);
    push_hit(2'd1, 8'd10,  8'd15,  8'd4, 6'd40, 2, 32'd0);
    push_hit(2'd3, 8'd200, 8'd10,  8'd9, 6'd63, 2, 32'd0);
    wait_drain("filter", 400);
    check_cnts("filter");
    CONF_TOT_MIN = 8'd0;

    // Back-pressure: FIFO fills at 4, then random drain
    rd_mode = 0;
    p0 = rd_pulses;
    for (int i = 0; i < 10; i++)
      push_hit(2'(i % 4), 8'(i * 10), 8'(i * 10 + i + 1), 8'(i), 6'(i), 0,
               {2'(i % 4), 6'(i), 8'(i), 8'(i * 10), 8'(i + 1)});
    repeat (80) @(negedge BUS_CLK);
    chk("bp.pops_when_full", 32'(rd_pulses - p0), 32'd4);
    chk("bp.out_not_empty", 32'(OUT_EMPTY), 32'd0);
    chk("bp.upstream_left", 32'(up_q.size()), 32'd6);
    rd_mode = 2;
    wait_drain("bp", 2000);
    chk("bp.total_pops", 32'(rd_pulses - p0), 32'd10);
    check_cnts("bp");

    // Asynchronous reset in CAPT with a word already in the FIFO
    rd_mode = 0;
    push_hit(2'd0, 8'd1, 8'd11, 8'd0, 6'd0, 0, {2'd0, 6'd0, 8'd0, 8'd1, 8'd10});
    repeat (10) @(negedge BUS_CLK);
    chk("arst.pre_not_empty", 32'(OUT_EMPTY), 32'd0);
    push_hit(2'd1, 8'd2, 8'd40, 8'd5, 6'd6, 0, {2'd1, 6'd6, 8'd5, 8'd2, 8'd38});
    wait_in_read("arst", 20);
    @(posedge BUS_CLK);
    #2 BUS_RST_N = 1'b0;
    #1;
    chk("arst.out_empty", 32'(OUT_EMPTY), 32'd1);
    chk("arst.out_data", OUT_DATA, 32'd0);
    chk("arst.in_read", 32'(IN_READ), 32'd0);
    exp_q.delete();
    exp_hit = 0; exp_drop = 0; exp_err = 0;
    check_cnts("arst");
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    @(negedge BUS_CLK);
    rd_mode = 1;
    push_hit(2'd2, 8'd30, 8'd33, 8'd12, 6'd20, 0, {2'd2, 6'd20, 8'd12, 8'd30, 8'd3});
    wait_drain("arst_post", 100);
    check_cnts("arst_post");

    // CONF_EN dropped during REQ: popped word completes, nothing more fetched
    p0 = rd_pulses;
    push_hit(2'd1, 8'd5, 8'd9,  8'd50, 6'd10, 0, {2'd1, 6'd10, 8'd50, 8'd5, 8'd4});
    push_hit(2'd2, 8'd6, 8'd16, 8'd51, 6'd11, 0, {2'd2, 6'd11, 8'd51, 8'd6, 8'd10});
    wait_in_read("en_drop", 20);
    CONF_EN = 1'b0;
    repeat (20) @(negedge BUS_CLK);
    chk("en_drop.pops", 32'(rd_pulses - p0), 32'd1);
    chk("en_drop.first_out", 32'(exp_q.size()), 32'd1);
    chk("en_drop.upstream_left", 32'(up_q.size()), 32'd1);
    CONF_EN = 1'b1;
    wait_drain("en_drop", 100);
    chk("en_drop.pops_after", 32'(rd_pulses - p0), 32'd2);

    // Saturation of the hit counter
    force dut.hit_cnt_q = 16'hFFFE;
    @(negedge BUS_CLK);
    release dut.hit_cnt_q;
    exp_hit = 16'hFFFE;
    push_hit(2'd0, 8'd0, 8'd1, 8'd0, 6'd1, 0, {2'd0, 6'd1, 8'd0, 8'd0, 8'd1});
    wait_drain("sat1", 100);
    chk("sat1.hit", 32'(HIT_CNT), 32'h0000FFFF);
    push_hit(2'd0, 8'd0, 8'd2, 8'd0, 6'd2, 0, {2'd0, 6'd2, 8'd0, 8'd0, 8'd2});
    wait_drain("sat2", 100);
    chk("sat2.hit", 32'(HIT_CNT), 32'h0000FFFF);
    check_cnts("sat2");

    chk("end.exp_left", 32'(exp_q.size()), 32'd0);
    chk("end.underflow", 32'(underflow), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
